// File: rtl/byteena_reg_arbiter.sv
// Two-port round-robin arbiter in front of a small byte-enabled register bank.
// One access commits per cycle; reads return registered data one cycle after grant.
module byteena_reg_arbiter #(
    parameter int DATA_W = 16,
    parameter int BE_W   = DATA_W / 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AW-1:0]     a_addr,
    input  logic [BE_W-1:0]   a_be,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AW-1:0]     b_addr,
    input  logic [BE_W-1:0]   b_be,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [CNT_W-1:0]  coll_cnt
);

    typedef enum logic {GNT_A, GNT_B} port_e;

    port_e             last_gnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_we;
    logic [AW-1:0]     acc_addr;
    logic [BE_W-1:0]   acc_be;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_in_range;
    logic [DATA_W-1:0] rd_word;

    // Grants are gated by resetn so nothing can commit during the reset cycle.
    always_comb begin
        a_gnt        = resetn & a_req & (~b_req | (last_gnt == GNT_B));
        b_gnt        = resetn & b_req & (~a_req | (last_gnt == GNT_A));
        acc_we       = a_gnt ? a_we    : b_we;
        acc_addr     = a_gnt ? a_addr  : b_addr;
        acc_be       = a_gnt ? a_be    : b_be;
        acc_wdata    = a_gnt ? a_wdata : b_wdata;
        acc_in_range = (32'(acc_addr) < 32'(DEPTH));
        rd_word      = '0;
        if (acc_in_range) begin
            rd_word = mem[acc_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            last_gnt <= GNT_B;
            coll_cnt <= '0;
        end else begin
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            if (a_gnt & ~a_we) begin
                a_rdata <= rd_word;
            end
            if (b_gnt & ~b_we) begin
                b_rdata <= rd_word;
            end
            if (a_gnt) begin
                last_gnt <= GNT_A;
            end else if (b_gnt) begin
                last_gnt <= GNT_B;
            end
            if (a_req && b_req && (coll_cnt != '1)) begin
                coll_cnt <= coll_cnt + 1'b1;
            end
            if ((a_gnt | b_gnt) && acc_we && acc_in_range) begin
                for (int unsigned i = 0; i < BE_W; i++) begin
                    if (acc_be[i]) begin
                        mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_byteena_reg_arbiter.sv
// Directed bench for byteena_reg_arbiter: a reference model predicts grants and
// counter values, and expected read data is queued at grant and popped on rvalid.
module tb_byteena_reg_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        a_req, a_we, b_req, b_we;
    logic [1:0]  a_addr, b_addr;
    logic [1:0]  a_be, b_be;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic [7:0]  coll_cnt;

    int tests  = 0;
    int failed = 0;

    typedef struct { bit port_b; logic [15:0] data; } rd_t;
    rd_t         q[$];
    logic [15:0] m_mem [4];
    bit          m_last_b;
    int          m_cnt;
    logic [15:0] m_ra, m_rb;

    always #5 clk = ~clk;

    byteena_reg_arbiter #(.DATA_W(16), .DEPTH(4), .AW(2), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .coll_cnt(coll_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [1:0] addr, input logic [1:0] be, input logic [15:0] wd);
        if (be[0]) m_mem[addr][7:0]  = wd[7:0];
        if (be[1]) m_mem[addr][15:8] = wd[15:8];
    endtask

    // One clock: check grants before the edge, apply the model, check outputs after it.
    task automatic tick(output logic ga, output logic gb);
        logic ea, eb, rva, rvb;
        rd_t  e;
        #2;
        ea  = resetn && a_req && (!b_req || m_last_b);
        eb  = resetn && b_req && (!a_req || !m_last_b);
        rva = 1'b0;
        rvb = 1'b0;
        chk("a_gnt", {31'b0, a_gnt}, {31'b0, ea});
        chk("b_gnt", {31'b0, b_gnt}, {31'b0, eb});
        ga = a_gnt;
        gb = b_gnt;
        if (!resetn) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            q.delete();
            m_last_b = 1'b1;
            m_cnt    = 0;
            m_ra     = '0;
            m_rb     = '0;
        end else begin
            if (a_req && b_req && m_cnt < 255) m_cnt++;
            if (ea) begin
                m_last_b = 1'b0;
                if (a_we) model_write(a_addr, a_be, a_wdata);
                else begin q.push_back('{1'b0, m_mem[a_addr]}); rva = 1'b1; end
            end else if (eb) begin
                m_last_b = 1'b1;
                if (b_we) model_write(b_addr, b_be, b_wdata);
                else begin q.push_back('{1'b1, m_mem[b_addr]}); rvb = 1'b1; end
            end
        end
        @(posedge clk);
        #1;
        chk("a_rvalid", {31'b0, a_rvalid}, {31'b0, rva});
        chk("b_rvalid", {31'b0, b_rvalid}, {31'b0, rvb});
        if ((rva || rvb) && q.size() > 0) begin
            e = q.pop_front();
            if (e.port_b) m_rb = e.data;
            else          m_ra = e.data;
        end
        chk("a_rdata", {16'b0, a_rdata}, {16'b0, m_ra});
        chk("b_rdata", {16'b0, b_rdata}, {16'b0, m_rb});
        chk("coll_cnt", {24'b0, coll_cnt}, m_cnt);
    endtask

    task automatic idle();
        a_req = 0; a_we = 0; a_addr = 0; a_be = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_be = 0; b_wdata = 0;
    endtask

    task automatic do_reset();
        logic ga, gb;
        idle();
        resetn = 1'b0;
        tick(ga, gb);
        tick(ga, gb);
        resetn = 1'b1;
    endtask

    initial begin
        logic ga, gb, prev_a;
        resetn   = 1'b0;
        m_last_b = 1'b1;
        m_cnt    = 0;
        m_ra     = '0;
        m_rb     = '0;
        foreach (m_mem[i]) m_mem[i] = 'x;
        do_reset();
        chk("reset_a_rdata", {16'b0, a_rdata}, 32'h0);
        chk("reset_coll", {24'b0, coll_cnt}, 32'h0);

        // 1: A reads every register of the cleared bank.
        for (int i = 0; i < 4; i++) begin
            a_req = 1; a_we = 0; a_addr = 2'(i);
            tick(ga, gb);
            chk("t1_rdata", {16'b0, a_rdata}, 32'h0);
        end
        idle(); tick(ga, gb);

        // 2: byte-merged writes, a be=0 no-op, then read back.
        a_req = 1; a_we = 1; a_addr = 1; a_be = 2'b11; a_wdata = 16'hABCD; tick(ga, gb);
        a_be = 2'b01; a_wdata = 16'h1234; tick(ga, gb);
        a_be = 2'b00; a_wdata = 16'hFFFF; tick(ga, gb);
        chk("t2_noop_gnt", {31'b0, ga}, 32'h1);
        a_we = 0; tick(ga, gb);
        chk("t2_rdata", {16'b0, a_rdata}, 32'hAB34);
        idle(); tick(ga, gb);
        chk("t2_hold", {16'b0, a_rdata}, 32'hAB34);

        // 3: contention from reset alternates A,B,A,B.
        do_reset();
        a_req = 1; b_req = 1; a_addr = 3; b_addr = 0;
        for (int i = 0; i < 4; i++) begin
            tick(ga, gb);
            chk("t3_order_a", {31'b0, ga}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("t3_order_b", {31'b0, gb}, (i % 2 == 1) ? 32'h1 : 32'h0);
        end
        chk("t3_coll", {24'b0, coll_cnt}, 32'd4);

        // 4: B upper-byte write, A reads it the very next cycle.
        do_reset();
        b_req = 1; b_we = 1; b_addr = 2; b_be = 2'b10; b_wdata = 16'h5600; tick(ga, gb);
        b_req = 0; a_req = 1; a_we = 0; a_addr = 2; tick(ga, gb);
        chk("t4_rdata", {16'b0, a_rdata}, 32'h5600);
        idle(); tick(ga, gb);

        // 5: reset lands on B's read; rvalid suppressed and bank cleared.
        resetn = 0; b_req = 1; b_we = 0; b_addr = 2; tick(ga, gb);
        chk("t5_gnt", {31'b0, gb}, 32'h0);
        chk("t5_rvalid", {31'b0, b_rvalid}, 32'h0);
        resetn = 1; tick(ga, gb);
        chk("t5_cleared", {16'b0, b_rdata}, 32'h0);
        idle(); tick(ga, gb);

        // 6: long contention saturates the counter; grants strictly alternate.
        do_reset();
        a_req = 1; b_req = 1; a_addr = 0; b_addr = 1;
        prev_a = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(ga, gb);
            chk("t6_alt", {31'b0, ga}, {31'b0, ~prev_a});
            prev_a = ga;
        end
        chk("t6_sat", {24'b0, coll_cnt}, 32'd255);
        idle(); tick(ga, gb);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
